// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the multiply/divide unit
package mdu_pkg;

   localparam int MDU_XLEN = 32;
   localparam int MDU_ITER = 32;

   typedef enum logic [2:0] {
      OP_MUL   = 3'b000,
      OP_MULH  = 3'b001,
      OP_MULHU = 3'b010,
      OP_RSVD  = 3'b011,
      OP_DIV   = 3'b100,
      OP_DIVU  = 3'b101,
      OP_MOD   = 3'b110,
      OP_MODU  = 3'b111
   } mdu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_t;

endpackage

// File: rtl/mdu_iter_step.sv
// rtl/mdu_iter_step.sv - one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step
module mdu_iter_step
   import mdu_pkg::*;
(
   input  logic [2*MDU_XLEN-1:0] acc_i,
   input  logic [MDU_XLEN-1:0]   opnd_i,
   input  logic                  div_i,
   output logic [2*MDU_XLEN-1:0] acc_o
);

   logic [MDU_XLEN:0]   sum;
   logic [MDU_XLEN:0]   rem;
   logic [MDU_XLEN-1:0] diff;
   logic                ge;

   // Multiply keeps the multiplier in the low half and retires one bit per step;
   // divide shifts the dividend up into the remainder half, quotient fills from the bottom.
   always_comb begin
      sum  = {1'b0, acc_i[63:32]} + {1'b0, (acc_i[0] ? opnd_i : 32'd0)};
      rem  = acc_i[63:31];
      ge   = rem >= {1'b0, opnd_i};
      diff = rem[31:0] - opnd_i;
      if (div_i) begin
         if (ge) begin
            acc_o = {diff, acc_i[30:0], 1'b1};
         end else begin
            acc_o = {rem[31:0], acc_i[30:0], 1'b0};
         end
      end else begin
         acc_o = {sum, acc_i[31:1]};
      end
   end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative 32-bit multiply/divide unit with fixed 34-cycle latency
module mdu
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      mdu_op,
   input  logic [XLEN-1:0] mdu_src0,
   input  logic [XLEN-1:0] mdu_src1,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] mdu_res,
   output logic            busy
);

   mdu_state_t  state_q, state_d;
   mdu_op_t     op_q, op_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] opnd_q, opnd_d;
   logic        neg_q, neg_d;
   logic        spec_q, spec_d;
   logic [31:0] spec_val_q, spec_val_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] res_q, res_d;
   logic        out_valid_q, out_valid_d;

   mdu_op_t     op_in;
   logic        sgn_op, s0, s1, div0, ovf;
   logic [31:0] mag0, mag1;
   logic [63:0] step_acc;
   logic [31:0] hi_neg, q_neg, r_neg, fix_val;

   mdu_iter_step u_step (
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .div_i  (op_q[2]),
      .acc_o  (step_acc)
   );

   // Signed ops work on magnitudes; 0x80000000 stays correct as an unsigned magnitude.
   always_comb begin
      op_in  = mdu_op_t'(mdu_op);
      sgn_op = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_MOD);
      s0     = sgn_op & mdu_src0[31];
      s1     = sgn_op & mdu_src1[31];
      mag0   = s0 ? (~mdu_src0 + 32'd1) : mdu_src0;
      mag1   = s1 ? (~mdu_src1 + 32'd1) : mdu_src1;
      div0   = op_in[2] && (mdu_src1 == 32'd0);
      ovf    = ((op_in == OP_DIV) || (op_in == OP_MOD)) &&
               (mdu_src0 == 32'h8000_0000) && (mdu_src1 == 32'hFFFF_FFFF);
   end

   always_comb begin
      hi_neg = ~acc_q[63:32] + {31'd0, (acc_q[31:0] == 32'd0)};
      q_neg  = ~acc_q[31:0] + 32'd1;
      r_neg  = ~acc_q[63:32] + 32'd1;
      case (op_q)
         OP_MUL:          fix_val = acc_q[31:0];
         OP_MULH:         fix_val = neg_q ? hi_neg : acc_q[63:32];
         OP_MULHU:        fix_val = acc_q[63:32];
         OP_DIV, OP_DIVU: fix_val = neg_q ? q_neg : acc_q[31:0];
         OP_MOD, OP_MODU: fix_val = neg_q ? r_neg : acc_q[63:32];
         default:         fix_val = 32'd0;
      endcase
      if (spec_q) begin
         fix_val = spec_val_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      opnd_d      = opnd_q;
      neg_d       = neg_q;
      spec_d      = spec_q;
      spec_val_d  = spec_val_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      out_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && !flush) begin
               state_d = ST_CALC;
               op_d    = op_in;
               cnt_d   = 5'(MDU_ITER - 1);
               if (op_in[2]) begin
                  acc_d  = {32'd0, mag0};
                  opnd_d = mag1;
               end else begin
                  acc_d  = {32'd0, mag1};
                  opnd_d = mag0;
               end
               neg_d      = ((op_in == OP_MOD) ? 1'b0 : s1) ^ s0;
               spec_d     = div0 || ovf;
               spec_val_d = div0 ? (op_in[1] ? mdu_src0 : 32'hFFFF_FFFF)
                                 : ((op_in == OP_DIV) ? 32'h8000_0000 : 32'd0);
            end
         end
         ST_CALC: begin
            acc_d = step_acc;
            if (cnt_q == 5'd0) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         ST_FIX: begin
            res_d   = fix_val;
            state_d = ST_DONE;
         end
         default: begin
            out_valid_d = 1'b1;
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
      endcase
      if (flush) begin
         state_d     = ST_IDLE;
         cnt_d       = 5'd0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_MUL;
         acc_q       <= 64'd0;
         opnd_q      <= 32'd0;
         neg_q       <= 1'b0;
         spec_q      <= 1'b0;
         spec_val_q  <= 32'd0;
         cnt_q       <= 5'd0;
         res_q       <= 32'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         opnd_q      <= opnd_d;
         neg_q       <= neg_d;
         spec_q      <= spec_d;
         spec_val_q  <= spec_val_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign mdu_res   = res_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard bench for the multiply/divide unit
module tb_mdu;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [2:0]  mdu_op;
   logic [31:0] mdu_src0, mdu_src1, mdu_res;

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mdu dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mdu_op    (mdu_op),
      .mdu_src0  (mdu_src0),
      .mdu_src1  (mdu_src1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mdu_res   (mdu_res),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] pu;
      longint      ps;
      int          sa, sb;
      logic        ov;
      sa = int'(a);
      sb = int'(b);
      pu = {32'd0, a} * {32'd0, b};
      ps = longint'(sa) * longint'(sb);
      ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'b000:  return pu[31:0];
         3'b001:  return ps[63:32];
         3'b010:  return pu[63:32];
         3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ov ? 32'h8000_0000 : 32'(sa / sb));
         3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110:  return (b == 0) ? a : (ov ? 32'd0 : 32'(sa % sb));
         3'b111:  return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
      int unsigned t0;
      int          n;
      logic [31:0] first;
      logic [31:0] exp;
      @(negedge clk);
      check("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
      mdu_op    = op;
      mdu_src0  = a;
      mdu_src1  = b;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      exp_q.push_back(model(op, a, b));
      @(negedge clk);
      in_valid = 1'b0;
      t0 = cyc;
      check("accepted", {31'd0, busy}, 32'd1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         check("result_timeout", 32'd0, 32'd1);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
         check($sformatf("latency_op%0d", op), cyc - t0, 32'd34);
         if (hold > 0) begin
            first = mdu_res;
            for (int i = 0; i < hold; i++) begin
               @(negedge clk);
               check("hold_res", mdu_res, first);
               check("hold_in_ready", {31'd0, in_ready}, 32'd0);
               check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            end
            out_ready = 1'b1;
         end
         if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            exp = exp_q.pop_front();
            check($sformatf("res_op%0d_%h_%h", op, a, b), mdu_res, exp);
         end
         @(posedge clk);
      end
   endtask

   initial begin
      logic [2:0] opsel [7];
      logic       seen;
      opsel = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      mdu_op = 3'd0; mdu_src0 = 32'd0; mdu_src1 = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_res", mdu_res, 32'd0);
      rst = 1'b0;

      do_op(3'b000, 32'hFFFF_FFFE, 32'd3, 0);
      do_op(3'b001, 32'hFFFF_FFFE, 32'd3, 0);
      do_op(3'b010, 32'hFFFF_FFFE, 32'd3, 0);
      check("mul_const", model(3'b000, 32'hFFFF_FFFE, 32'd3), 32'hFFFF_FFFA);
      do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(3'b101, 32'd7, 32'd2, 0);
      do_op(3'b111, 32'd7, 32'd2, 0);
      do_op(3'b101, 32'd5, 32'd0, 0);
      do_op(3'b111, 32'd5, 32'd0, 0);
      do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(3'b100, 32'hFFFF_FFF9, 32'd0, 0);
      do_op(3'b011, 32'd5, 32'd6, 0);
      do_op(3'b000, 32'd123, 32'd456, 0);
      do_op(3'b000, 32'hDEAD_BEEF, 32'h0001_2345, 0);
      do_op(3'b100, 32'd100, 32'd7, 10);
      for (int i = 0; i < 12; i++) begin
         do_op(opsel[$urandom_range(6)], $urandom,
               ($urandom_range(3) == 0) ? 32'($urandom_range(5)) : $urandom, 0);
      end

      // reset mid-CALC
      @(negedge clk);
      mdu_op = 3'b000; mdu_src0 = 32'd9; mdu_src1 = 32'd9; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_res", mdu_res, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_in_ready", {31'd0, in_ready}, 32'd1);

      // flush during the 15th CALC cycle
      mdu_op = 3'b101; mdu_src0 = 32'd1000; mdu_src1 = 32'd3; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (14) @(negedge clk);
      check("pre_flush_busy", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check("flush_no_out_valid", {31'd0, seen}, 32'd0);

      // flush with in_valid in IDLE must not accept
      in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check("flush_idle_no_accept", {31'd0, busy}, 32'd0);

      do_op(3'b110, 32'hFFFF_FF9C, 32'd7, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
